// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst types, response codes, size helper and
// the write-master FSM state encoding.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  // AxSIZE encoding for a bus of the given width in bits.
  function automatic logic [2:0] size_from_width(input int unsigned width);
    return 3'($clog2(width / 8));
  endfunction

endpackage

// File: rtl/burst_splitter.sv
// Combinational burst arithmetic: next burst length from the remaining beat
// count, address after the current burst, and per-beat remaining decrement.
module burst_splitter
  import axi_pkg::*;
#(
  parameter int unsigned AXI_DW_g  = 64,
  parameter int unsigned AXI_AW_g  = 32,
  parameter int unsigned MAX_LEN_g = 16
) (
  input  logic [AXI_AW_g-1:0] addr_i,
  input  logic [15:0]         rem_i,
  input  logic [7:0]          cur_len_i,
  output logic [7:0]          len_o,
  output logic [AXI_AW_g-1:0] next_addr_o,
  output logic [15:0]         rem_dec_o
);

  localparam logic [2:0]  Size   = size_from_width(AXI_DW_g);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN_g);

  logic [15:0] beats;

  always_comb begin
    beats       = (rem_i > MaxLen) ? MaxLen : rem_i;
    // With MAX_LEN_g = 256 the 256-1 result still fits in the 8-bit field.
    len_o       = 8'(beats - 16'd1);
    next_addr_o = addr_i + ((AXI_AW_g'(cur_len_i) + AXI_AW_g'(1)) << Size);
    rem_dec_o   = rem_i - 16'd1;
  end

endmodule

// File: rtl/axi_burst_wr_mst.sv
// AXI4 write-burst master: splits a (start address, beat count) command into
// INCR bursts of at most MAX_LEN_g beats, one burst outstanding at a time.
module axi_burst_wr_mst
  import axi_pkg::*;
#(
  parameter int unsigned AXI_DW_g  = 64,
  parameter int unsigned AXI_AW_g  = 32,
  parameter int unsigned MAX_LEN_g = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [AXI_AW_g-1:0] cmd_addr_i,
  input  logic [15:0]         cmd_beats_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [AXI_DW_g-1:0] s_data_i,
  output logic                m_axi_awvalid_o,
  input  logic                m_axi_awready_i,
  output logic [AXI_AW_g-1:0] m_axi_awaddr_o,
  output logic [7:0]          m_axi_awlen_o,
  output logic [2:0]          m_axi_awsize_o,
  output logic [1:0]          m_axi_awburst_o,
  output logic [2:0]          m_axi_awprot_o,
  output logic [3:0]          m_axi_awcache_o,
  output logic                m_axi_wvalid_o,
  input  logic                m_axi_wready_i,
  output logic [AXI_DW_g-1:0] m_axi_wdata_o,
  output logic [3:0]          m_axi_wstrb_o,
  output logic                m_axi_wlast_o,
  input  logic                m_axi_bvalid_i,
  output logic                m_axi_bready_o,
  input  logic [1:0]          m_axi_bresp_i,
  output logic                done_o,
  output logic                err_o
);

  wr_state_e           state_q, state_d;
  logic [AXI_AW_g-1:0] addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [15:0]         split_rem;
  logic [7:0]          split_len;
  logic [AXI_AW_g-1:0] split_addr;
  logic [15:0]         split_rem_dec;
  logic                in_data;
  logic                w_hs;

  // In IDLE the first burst is sized straight from the incoming command.
  assign split_rem = (state_q == IDLE) ? cmd_beats_i : rem_q;

  burst_splitter #(
    .AXI_DW_g  (AXI_DW_g),
    .AXI_AW_g  (AXI_AW_g),
    .MAX_LEN_g (MAX_LEN_g)
  ) u_burst_splitter (
    .addr_i      (addr_q),
    .rem_i       (split_rem),
    .cur_len_i   (len_q),
    .len_o       (split_len),
    .next_addr_o (split_addr),
    .rem_dec_o   (split_rem_dec)
  );

  assign in_data = (state_q == DATA);
  assign w_hs    = in_data && s_valid_i && m_axi_wready_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          rem_d  = cmd_beats_i;
          len_d  = split_len;
          err_d  = 1'b0;
          if (cmd_beats_i == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        if (m_axi_awready_i) begin
          state_d = DATA;
          cnt_d   = 8'd0;
        end
      end
      DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          rem_d = split_rem_dec;
          if (cnt_q == len_q) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (m_axi_bvalid_i) begin
          if (m_axi_bresp_i != RESP_OKAY) begin
            err_d = 1'b1;
          end
          addr_d = split_addr;
          if (rem_q == 16'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ADDR;
            len_d   = split_len;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o     = (state_q == IDLE);
  assign m_axi_awvalid_o = (state_q == ADDR);
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = len_q;
  assign m_axi_awsize_o  = size_from_width(AXI_DW_g);
  assign m_axi_awburst_o = BURST_INCR;
  assign m_axi_awprot_o  = 3'b000;
  assign m_axi_awcache_o = 4'b0000;

  // Stream and W channel are coupled only while a burst is in its data phase.
  assign m_axi_wvalid_o  = in_data && s_valid_i;
  assign s_ready_o       = in_data && m_axi_wready_i;
  assign m_axi_wdata_o   = in_data ? s_data_i : '0;
  assign m_axi_wstrb_o   = 4'hF;
  assign m_axi_wlast_o   = in_data && (cnt_q == len_q);
  assign m_axi_bready_o  = (state_q == RESP);

  assign done_o = done_q;
  assign err_o  = err_q;

endmodule
